// File: rtl/rng_lutsr_gen_if.sv
// rng_lutsr_gen_if -- seed and output handshake bundle for rng_lutsr_gen.
//   seed_valid / seed_ready / seed_data : parallel seed beats into the generator
//   rng_valid  / rng_ready  / rng       : random words out of the generator
// master = the side that supplies seeds and consumes words; slave = the generator.
interface rng_lutsr_gen_if #(
    parameter int W = 64
);
    logic         seed_valid;
    logic         seed_ready;
    logic [W-1:0] seed_data;
    logic         rng_valid;
    logic         rng_ready;
    logic [W-1:0] rng;

    modport master (
        output seed_valid, seed_data, rng_ready,
        input  seed_ready, rng_valid, rng
    );

    modport slave (
        input  seed_valid, seed_data, rng_ready,
        output seed_ready, rng_valid, rng
    );
endinterface

// File: rtl/rng_lutsr_gen.sv
// rng_lutsr_gen -- parametrised LUT-shift-register random-bit generator.
// W lanes of K-deep shift registers (one SRLC32E each, tap at K-1) feed a
// W-bit state register r through a 5-input XOR per bit. The generator is
// loaded by K+1 parallel seed beats, optionally runs WARMUP discarded
// advances, then delivers one word per valid/ready handshake.
// Ports:
//   clk     in   clock
//   rst_n   in   asynchronous active-low reset
//   bus     if   slave side of rng_lutsr_gen_if (seed and rng handshakes)
//   seeded  out  high once a full K+1 beat seed has been loaded

// One lane: K-deep shift register without reset so it maps onto an SRL.
// q is the oldest bit, i.e. the one shifted in K pushes ago.
module rng_lutsr_lane #(
    parameter int K = 32
) (
    input  logic clk,
    input  logic shift,
    input  logic d,
    output logic q
);
    logic [K-1:0] sr;

    always_ff @(posedge clk)
        if (shift) sr <= {sr[K-2:0], d};

    assign q = sr[K-1];
endmodule

module rng_lutsr_gen #(
    parameter int W      = 64,
    parameter int K      = 32,
    parameter int T1     = 1,
    parameter int T2     = 5,
    parameter int T3     = 17,
    parameter int T4     = 40,
    parameter int WARMUP = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    rng_lutsr_gen_if.slave  bus,
    output logic            seeded
);
    localparam logic [1:0] ST_UNSEEDED = 2'd0;
    localparam logic [1:0] ST_SEEDING  = 2'd1;
    localparam logic [1:0] ST_WARMUP   = 2'd2;
    localparam logic [1:0] ST_RUN      = 2'd3;

    localparam int            BW        = $clog2(K + 2);
    localparam logic [BW-1:0] LAST_BEAT = BW'(K + 1);
    localparam logic [15:0]   WARM_INIT = 16'(WARMUP);

    logic [1:0]    state;
    logic [BW-1:0] beat;
    logic [BW-1:0] beat_next;
    logic [15:0]   warm;
    logic [W-1:0]  r;
    logic [W-1:0]  f;
    logic [W-1:0]  nxt;
    logic          accept;
    logic          advance;
    logic          push;

    // Ready is simply "not in reset"; the generator can always take a beat.
    assign bus.seed_ready = rst_n;
    assign accept         = bus.seed_valid & bus.seed_ready;

    // rng_valid comes from registered state only, so rng_ready never reaches
    // rng or rng_valid combinationally.
    assign bus.rng_valid  = (state == ST_RUN);
    assign bus.rng        = r;

    // A beat arriving outside SEEDING starts a fresh seed sequence.
    assign beat_next = (state == ST_SEEDING) ? beat + 1'b1 : BW'(1);

    // A seed beat wins over both warm-up and handshake advances.
    assign advance = !accept &&
                     ((state == ST_WARMUP) || (state == ST_RUN && bus.rng_ready));

    // Lanes shift on seed steps as well as advances; that is what lets K+1
    // seed beats overwrite every lane bit.
    assign push = accept | advance;

    for (genvar i = 0; i < W; i++) begin : g_lane
        rng_lutsr_lane #(.K(K)) u_lane (
            .clk   (clk),
            .shift (push),
            .d     (r[(i + 1) % W]),
            .q     (f[i])
        );

        assign nxt[i] = f[i] ^ f[(i + T1) % W] ^ f[(i + T2) % W] ^
                        f[(i + T3) % W] ^ f[(i + T4) % W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_UNSEEDED;
            beat   <= '0;
            warm   <= '0;
            seeded <= 1'b0;
            r      <= '0;
        end else if (accept) begin
            r    <= bus.seed_data;
            beat <= beat_next;
            if (beat_next == LAST_BEAT) begin
                seeded <= 1'b1;
                warm   <= WARM_INIT;
                state  <= (WARMUP == 0) ? ST_RUN : ST_WARMUP;
            end else begin
                state  <= ST_SEEDING;
            end
        end else if (advance) begin
            r <= nxt;
            if (state == ST_WARMUP) begin
                warm <= warm - 16'd1;
                // Leaving on the final discarded advance makes the next word
                // the first one the consumer sees.
                if (warm == 16'd1) state <= ST_RUN;
            end
        end
    end
endmodule

// File: tb/tb_rng_lutsr_gen.sv
// tb_rng_lutsr_gen -- self-checking bench for rng_lutsr_gen.
// Two instances share one clock: dut_a (W=8, K=2, taps 1,2,3,5, no warm-up)
// and dut_b (default parameters). The reference model keeps a history of
// r words: every step (seed or advance) appends one word, and an advance
// produces the XOR of five rotations of the word appended K+1 steps earlier.
module tb_rng_lutsr_gen;
    localparam int WARM_B = 64;
    localparam int KB     = 32;

    logic clk   = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    logic seeded_a;
    logic seeded_b;

    always #5 clk = ~clk;

    rng_lutsr_gen_if #(.W(8))  ifa ();
    rng_lutsr_gen_if #(.W(64)) ifb ();

    rng_lutsr_gen #(.W(8), .K(2), .T1(1), .T2(2), .T3(3), .T4(5), .WARMUP(0)) dut_a (
        .clk    (clk),
        .rst_n  (rst_a),
        .bus    (ifa.slave),
        .seeded (seeded_a)
    );

    rng_lutsr_gen dut_b (
        .clk    (clk),
        .rst_n  (rst_b),
        .bus    (ifb.slave),
        .seeded (seeded_b)
    );

    int ntests = 0;
    int nfail  = 0;

    // reference model state
    logic [127:0] hist[$];
    int           mw;
    int           mk;
    int           mtap[5];

    function automatic logic [127:0] adv_word(input logic [127:0] x);
        logic [127:0] y;
        y = '0;
        // bit i of an advance = XOR over taps of x rotated right by (tap+1)
        for (int i = 0; i < mw; i++)
            for (int t = 0; t < 5; t++)
                y[i] = y[i] ^ x[(i + mtap[t] + 1) % mw];
        return y;
    endfunction

    task automatic model_trim();
        while (hist.size() > 80) void'(hist.pop_front());
    endtask

    task automatic model_seed(input logic [127:0] s);
        hist.push_back(s);
        model_trim();
    endtask

    task automatic model_adv();
        logic [127:0] x;
        x = hist[hist.size() - 1 - mk];
        hist.push_back(adv_word(x));
        model_trim();
    endtask

    function automatic logic [127:0] mexp();
        return hist[hist.size() - 1];
    endfunction

    task automatic cfg_a();
        mw = 8; mk = 2; mtap = '{0, 1, 2, 3, 5};
        hist.delete(); hist.push_back('0);
    endtask

    task automatic cfg_b();
        mw = 64; mk = KB; mtap = '{0, 1, 5, 17, 40};
        hist.delete(); hist.push_back('0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus helper: n random seed beats into dut_b, mirrored into the model.
    task automatic seed_b(input int n);
        for (int b = 0; b < n; b++) begin
            ifb.seed_data  = {$urandom(), $urandom()};
            ifb.seed_valid = 1'b1;
            tick();
            model_seed({64'd0, ifb.seed_data});
        end
        ifb.seed_valid = 1'b0;
    endtask

    // Stimulus helper: WARM_B cycles of warm-up on dut_b; reports how many
    // observed cycles had rng_valid low and rng_valid at the end.
    task automatic warm_b(output int low, output logic vld_end);
        low = 0;
        for (int c = 0; c < WARM_B; c++) begin
            if (!ifb.rng_valid) low++;
            tick();
            model_adv();
        end
        vld_end = ifb.rng_valid;
    endtask

    task automatic test_reset();
        ifa.seed_valid = 1'b1; ifa.seed_data = 8'hA5;  ifa.rng_ready = 1'b1;
        ifb.seed_valid = 1'b1; ifb.seed_data = 64'h1234; ifb.rng_ready = 1'b1;
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (3) tick();
        ntests++;
        if ({ifa.seed_ready, ifa.rng_valid, seeded_a, ifa.rng} !== 11'd0) begin
            nfail++;
            $display("FAIL reset_a: got rdy/vld/seeded/rng=%b/%b/%b/%h, want 0/0/0/00",
                     ifa.seed_ready, ifa.rng_valid, seeded_a, ifa.rng);
        end
        ntests++;
        if ({ifb.seed_ready, ifb.rng_valid, seeded_b, ifb.rng} !== 67'd0) begin
            nfail++;
            $display("FAIL reset_b: got rdy/vld/seeded/rng=%b/%b/%b/%h, want all 0",
                     ifb.seed_ready, ifb.rng_valid, seeded_b, ifb.rng);
        end
        ifa.seed_valid = 1'b0; ifb.seed_valid = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            ntests++;
            if ({ifa.seed_ready, ifa.rng_valid, seeded_a} !== 3'b100) begin
                nfail++;
                $display("FAIL release_a: got rdy/vld/seeded=%b%b%b, want 100",
                         ifa.seed_ready, ifa.rng_valid, seeded_a);
            end
            ntests++;
            if ({ifb.seed_ready, ifb.rng_valid, seeded_b} !== 3'b100) begin
                nfail++;
                $display("FAIL release_b: got rdy/vld/seeded=%b%b%b, want 100",
                         ifb.seed_ready, ifb.rng_valid, seeded_b);
            end
        end
    endtask

    task automatic test_known_seq();
        logic [7:0]   seeds[3];
        logic [7:0]   known[5];
        logic [127:0] e;
        seeds = '{8'h01, 8'h00, 8'h00};
        known = '{8'h00, 8'hF4, 8'h00, 8'h00, 8'h45};
        cfg_a();
        ifa.rng_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            ifa.seed_data  = seeds[b];
            ifa.seed_valid = 1'b1;
            tick();
            model_seed({120'd0, seeds[b]});
            ntests++;
            if (ifa.rng_valid !== (b == 2)) begin
                nfail++;
                $display("FAIL seed_valid_rise beat %0d: got rng_valid=%b, want %b",
                         b, ifa.rng_valid, (b == 2));
            end
        end
        ifa.seed_valid = 1'b0;
        ntests++;
        if (seeded_a !== 1'b1) begin
            nfail++;
            $display("FAIL seeded_a: got %b, want 1", seeded_a);
        end
        for (int j = 0; j < 25; j++) begin
            e = mexp();
            ntests++;
            if ({ifa.rng_valid, ifa.rng} !== {1'b1, e[7:0]}) begin
                nfail++;
                $display("FAIL model_a word %0d: got vld=%b rng=%h, want vld=1 rng=%h",
                         j, ifa.rng_valid, ifa.rng, e[7:0]);
            end
            if (j < 5) begin
                ntests++;
                if (ifa.rng !== known[j]) begin
                    nfail++;
                    $display("FAIL known_a word %0d: got %h, want %h", j, ifa.rng, known[j]);
                end
            end
            tick();
            model_adv();
        end
    endtask

    task automatic test_zero_seed();
        int bad;
        ifa.rng_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            ifa.seed_data  = 8'h00;
            ifa.seed_valid = 1'b1;
            tick();
            model_seed('0);
        end
        ifa.seed_valid = 1'b0;
        bad = 0;
        for (int j = 0; j < 1000; j++) begin
            ntests++;
            if ({ifa.rng_valid, ifa.rng} !== 9'h100) begin
                nfail++;
                bad++;
                if (bad <= 5)
                    $display("FAIL zero_seed handshake %0d: got vld=%b rng=%h, want vld=1 rng=00",
                             j, ifa.rng_valid, ifa.rng);
            end
            tick();
            model_adv();
        end
    endtask

    task automatic test_warmup();
        int           low;
        logic         vld_end;
        logic [127:0] e;
        cfg_b();
        ifb.rng_ready = 1'b1;
        for (int b = 0; b < KB + 1; b++) begin
            ifb.seed_data  = {$urandom(), $urandom()};
            ifb.seed_valid = 1'b1;
            tick();
            model_seed({64'd0, ifb.seed_data});
            ntests++;
            if (seeded_b !== (b == KB)) begin
                nfail++;
                $display("FAIL seeded_b beat %0d: got %b, want %b", b, seeded_b, (b == KB));
            end
        end
        ifb.seed_valid = 1'b0;
        warm_b(low, vld_end);
        ntests++;
        if (low != WARM_B || vld_end !== 1'b1) begin
            nfail++;
            $display("FAIL warmup_len: got %0d low cycles then vld=%b, want %0d then 1",
                     low, vld_end, WARM_B);
        end
        e = mexp();
        ntests++;
        if (ifb.rng !== e[63:0]) begin
            nfail++;
            $display("FAIL first_word_b: got %h, want %h", ifb.rng, e[63:0]);
        end
    endtask

    task automatic test_backpressure();
        logic         rdy;
        logic [63:0]  prev;
        logic [127:0] e;
        for (int j = 0; j < 300; j++) begin
            rdy = ($urandom_range(0, 1) == 1);
            ifb.rng_ready = rdy;
            e = mexp();
            prev = ifb.rng;
            ntests++;
            if ({ifb.rng_valid, ifb.rng} !== {1'b1, e[63:0]}) begin
                nfail++;
                $display("FAIL bp_model cycle %0d: got vld=%b rng=%h, want vld=1 rng=%h",
                         j, ifb.rng_valid, ifb.rng, e[63:0]);
            end
            tick();
            if (rdy) begin
                model_adv();
            end else begin
                ntests++;
                if (ifb.rng !== prev) begin
                    nfail++;
                    $display("FAIL bp_hold cycle %0d: got %h, want %h", j, ifb.rng, prev);
                end
            end
        end
    endtask

    task automatic test_reseed_run();
        int           low;
        logic         vld_end;
        logic [63:0]  s;
        logic [127:0] e;
        ifb.rng_ready = 1'b1;
        for (int j = 0; j < 10; j++) begin
            e = mexp();
            ntests++;
            if (ifb.rng !== e[63:0]) begin
                nfail++;
                $display("FAIL pre_reseed word %0d: got %h, want %h", j, ifb.rng, e[63:0]);
            end
            tick();
            model_adv();
        end
        // first beat lands on a live handshake: the seed step must win
        s = {$urandom(), $urandom()};
        ifb.seed_data  = s;
        ifb.seed_valid = 1'b1;
        tick();
        model_seed({64'd0, s});
        ifb.seed_valid = 1'b0;
        ntests++;
        if ({ifb.rng_valid, ifb.rng} !== {1'b0, s}) begin
            nfail++;
            $display("FAIL reseed_first_beat: got vld=%b rng=%h, want vld=0 rng=%h",
                     ifb.rng_valid, ifb.rng, s);
        end
        for (int g = 0; g < 5; g++) begin
            tick();
            ntests++;
            if ({ifb.rng_valid, ifb.rng} !== {1'b0, s}) begin
                nfail++;
                $display("FAIL seeding_stall gap %0d: got vld=%b rng=%h, want vld=0 rng=%h",
                         g, ifb.rng_valid, ifb.rng, s);
            end
        end
        seed_b(KB);
        warm_b(low, vld_end);
        ntests++;
        if (low != WARM_B || vld_end !== 1'b1) begin
            nfail++;
            $display("FAIL reseed_warmup: got %0d low cycles then vld=%b, want %0d then 1",
                     low, vld_end, WARM_B);
        end
        for (int j = 0; j < 20; j++) begin
            e = mexp();
            ntests++;
            if ({ifb.rng_valid, ifb.rng} !== {1'b1, e[63:0]}) begin
                nfail++;
                $display("FAIL reseed_word %0d: got vld=%b rng=%h, want vld=1 rng=%h",
                         j, ifb.rng_valid, ifb.rng, e[63:0]);
            end
            tick();
            model_adv();
        end
    endtask

    task automatic test_reset_warmup();
        int           low;
        logic         vld_end;
        logic [127:0] e;
        ifb.rng_ready = 1'b1;
        seed_b(KB + 1);
        repeat (10) tick();
        rst_b = 1'b0;
        #1;
        ntests++;
        if ({ifb.seed_ready, ifb.rng_valid, seeded_b, ifb.rng} !== 67'd0) begin
            nfail++;
            $display("FAIL async_reset: got rdy/vld/seeded/rng=%b/%b/%b/%h, want all 0",
                     ifb.seed_ready, ifb.rng_valid, seeded_b, ifb.rng);
        end
        tick();
        rst_b = 1'b1;
        model_seed('0);
        tick();
        ntests++;
        if ({ifb.rng_valid, seeded_b} !== 2'b00) begin
            nfail++;
            $display("FAIL post_reset_idle: got vld/seeded=%b%b, want 00", ifb.rng_valid, seeded_b);
        end
        seed_b(KB + 1);
        warm_b(low, vld_end);
        ntests++;
        if (low != WARM_B || vld_end !== 1'b1) begin
            nfail++;
            $display("FAIL rst_reseed_warmup: got %0d low cycles then vld=%b, want %0d then 1",
                     low, vld_end, WARM_B);
        end
        for (int j = 0; j < 30; j++) begin
            e = mexp();
            ntests++;
            if ({ifb.rng_valid, ifb.rng} !== {1'b1, e[63:0]}) begin
                nfail++;
                $display("FAIL rst_reseed_word %0d: got vld=%b rng=%h, want vld=1 rng=%h",
                         j, ifb.rng_valid, ifb.rng, e[63:0]);
            end
            tick();
            model_adv();
        end
    endtask

    initial begin
        ifa.seed_valid = 1'b0; ifa.seed_data = '0; ifa.rng_ready = 1'b0;
        ifb.seed_valid = 1'b0; ifb.seed_data = '0; ifb.rng_ready = 1'b0;
        test_reset();
        test_known_seq();
        test_zero_seed();
        test_warmup();
        test_backpressure();
        test_reseed_run();
        test_reset_warmup();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded %0d ns without finishing", 2000000);
        $fatal(1);
    end
endmodule
